hamming_enc_arbiter: RTL and testbench

// - Shares one Hamming encoder (16-bit data in, 21-bit codeword out) among N_REQ requesters.
// - Round-robin arbitration; valid/ready on every side.
// - In-order tag FIFO returns each codeword to its requester's id.
// - Sits between requester channels and the encoder's iData/iValid/oReady, oData/oValid/iReady.

---
 rtl/hamming_enc_arbiter.sv | 156 +++++++++++++++
 tb/tb_hamming_enc_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_enc_arbiter.sv
// Round-robin arbiter that shares one Hamming encoder among N_REQ requesters and returns each codeword tagged with its requester id.
// Optional HAMM_ARB_STATS_EN adds grant and stall counters.
module hamming_enc_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 16,
  parameter int CODE_W    = 21,
  parameter int TAG_DEPTH = 4,
  parameter int ID_W      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]       enc_iData,
  output logic                    enc_iValid,
  input  logic                    enc_oReady,
  input  logic [CODE_W-1:0]       enc_oData,
  input  logic                    enc_oValid,
  output logic                    enc_iReady,
  output logic                    res_valid,
  output logic [CODE_W-1:0]       res_data,
  output logic [ID_W-1:0]         res_id,
  input  logic                    res_ready,
  output logic                    err_orphan,
  output logic                    dbgState
`ifdef HAMM_ARB_STATS_EN
  ,output logic [N_REQ*16-1:0]    stat_grants
  ,output logic [15:0]            stat_stall
  ,input  logic                   stat_clr
`endif
);

  // Handshake rule on every channel: a transfer happens in a cycle where valid
  // and ready are both high; a raised valid holds its data until that transfer.

  localparam int PW = $clog2(TAG_DEPTH);
  localparam logic [PW:0] FULL_CNT = TAG_DEPTH[PW:0];
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] OFFER = 1'b1;

  logic [0:0]        state;
  logic [ID_W-1:0]   rrLast;
  logic [ID_W-1:0]   pendId;
  logic [ID_W-1:0]   grantIdx;
  logic              grantValid;
  logic              canGrant;
  logic              push;
  logic              pop;
  logic              fifoEmpty;
  logic              fifoFull;
  logic [DATA_W-1:0] hold;
  logic [ID_W-1:0]   tagMem [TAG_DEPTH];
  logic [PW-1:0]     wrPtr;
  logic [PW-1:0]     rdPtr;
  logic [PW:0]       count;

  // Search starts one past the last winner, so every requester gets a turn.
  always_comb begin : grantSearch
    int idx;
    idx        = 0;
    grantValid = 1'b0;
    grantIdx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(rrLast) + k) % N_REQ;
      if (!grantValid && req_valid[idx]) begin
        grantValid = 1'b1;
        grantIdx   = ID_W'(idx);
      end
    end
  end

  assign fifoEmpty  = (count == '0);
  assign fifoFull   = (count == FULL_CNT);
  assign canGrant   = rst && (state == IDLE) && grantValid && !fifoFull;
  assign req_ready  = canGrant ? (N_REQ'(1) << grantIdx) : '0;
  assign enc_iValid = (state == OFFER);
  assign enc_iData  = hold;
  assign push       = (state == OFFER) && enc_oReady;
  assign enc_iReady = res_ready && !fifoEmpty;
  assign res_valid  = enc_oValid && !fifoEmpty;
  assign res_data   = enc_oData;
  assign res_id     = tagMem[rdPtr];
  assign pop        = enc_oValid && enc_iReady;
  assign dbgState   = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      rrLast <= ID_W'(N_REQ - 1);
      hold   <= '0;
      pendId <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (canGrant) begin
            hold   <= req_data[int'(grantIdx)*DATA_W +: DATA_W];
            pendId <= grantIdx;
            rrLast <= grantIdx;
            state  <= OFFER;
          end
        end
        OFFER: begin
          if (enc_oReady) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag FIFO: pointers and count reset; stale entries are unreachable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) tagMem[wrPtr] <= pendId;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_orphan <= 1'b0;
    else if (enc_oValid && fifoEmpty) err_orphan <= 1'b1;
  end

`ifdef HAMM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_grants <= '0;
      stat_stall  <= '0;
    end else if (stat_clr) begin
      stat_grants <= '0;
      stat_stall  <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_ready[i] && (stat_grants[i*16 +: 16] != 16'hFFFF))
          stat_grants[i*16 +: 16] <= stat_grants[i*16 +: 16] + 16'd1;
      end
      if ((state == OFFER) && !enc_oReady && (stat_stall != 16'hFFFF))
        stat_stall <= stat_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hamming_enc_arbiter.sv
// Directed bench for hamming_enc_arbiter: the bench plays the encoder and result consumer;
// a monitor checks returned codewords and ids against an expected queue.
module tb_hamming_enc_arbiter;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 16;
  localparam int CODE_W = 21;
  localparam int ID_W   = 2;

  logic                    clk;
  logic                    rst;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]       enc_iData;
  logic                    enc_iValid;
  logic                    enc_oReady;
  logic [CODE_W-1:0]       enc_oData;
  logic                    enc_oValid;
  logic                    enc_iReady;
  logic                    res_valid;
  logic [CODE_W-1:0]       res_data;
  logic [ID_W-1:0]         res_id;
  logic                    res_ready;
  logic                    err_orphan;
  logic                    dbgState;
`ifdef HAMM_ARB_STATS_EN
  logic [N_REQ*16-1:0]     stat_grants;
  logic [15:0]             stat_stall;
  logic                    stat_clr;
`endif

  int nAssert = 0;
  int nFail   = 0;
  logic [ID_W+CODE_W-1:0] exp_q[$];
  logic [CODE_W-1:0]      code_q[$];
  logic [ID_W+CODE_W-1:0] expEntry;
  logic [DATA_W-1:0]      words[N_REQ];

  hamming_enc_arbiter #(
    .N_REQ(N_REQ), .DATA_W(DATA_W), .CODE_W(CODE_W), .TAG_DEPTH(4), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .enc_iData(enc_iData), .enc_iValid(enc_iValid), .enc_oReady(enc_oReady),
    .enc_oData(enc_oData), .enc_oValid(enc_oValid), .enc_iReady(enc_iReady),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .res_ready(res_ready),
    .err_orphan(err_orphan), .dbgState(dbgState)
`ifdef HAMM_ARB_STATS_EN
    , .stat_grants(stat_grants), .stat_stall(stat_stall), .stat_clr(stat_clr)
`endif
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CODE_W-1:0] mkCode(input logic [DATA_W-1:0] d);
    return {d[4:0] ^ 5'h1B, d};
  endfunction

  function automatic logic [N_REQ-1:0] oneHot(input int g);
    logic [N_REQ-1:0] v;
    v = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setData(input int id, input logic [DATA_W-1:0] w);
    req_data[id*DATA_W +: DATA_W] = w;
  endtask

  task automatic loadWords();
    for (int i = 0; i < N_REQ; i++) setData(i, words[i]);
  endtask

  task automatic expectWord(input int id, input logic [DATA_W-1:0] w);
    logic [ID_W-1:0] idv;
    idv = ID_W'(id);
    exp_q.push_back({idv, mkCode(w)});
    code_q.push_back(mkCode(w));
  endtask

  // Encoder side: present the oldest codeword until the arbiter takes it.
  task automatic returnOne(input logic startReady);
    logic accepted;
    accepted   = 1'b0;
    enc_oValid = 1'b1;
    enc_oData  = code_q.pop_front();
    for (int k = 0; k < 8 && !accepted; k++) begin
      res_ready = startReady ^ k[0];
      @(negedge clk);
      if (!res_ready) begin
        check("res_valid_while_blocked", res_valid, 1);
        check("enc_iReady_while_blocked", enc_iReady, 0);
      end else begin
        accepted = enc_iReady;
      end
      tick();
    end
    check("return_accepted", accepted, 1);
    enc_oValid = 1'b0;
    res_ready  = 1'b1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("res_unexpected", res_valid, 0);
      end else begin
        expEntry = exp_q.pop_front();
        check("res_id", res_id, expEntry[CODE_W +: ID_W]);
        check("res_data", res_data, expEntry[CODE_W-1:0]);
      end
    end
  end

  initial begin
    words[0] = 16'h1001; words[1] = 16'h2002; words[2] = 16'h3003; words[3] = 16'h4004;
    rst = 1'b0; req_valid = 4'b1111; req_data = '0; loadWords();
    enc_oReady = 1'b1; enc_oData = '0; enc_oValid = 1'b0; res_ready = 1'b1;
`ifdef HAMM_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_enc_iValid", enc_iValid, 0);
    check("rst_enc_iData", enc_iData, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_enc_iReady", enc_iReady, 0);
    check("rst_err_orphan", err_orphan, 0);
    check("rst_state", dbgState, 0);
    tick();
    rst = 1'b1;

    // Round-robin from reset: 0,1,2,3,0, each result returned right away
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rr_grant", req_ready, oneHot(i % 4));
      expectWord(i % 4, words[i % 4]);
      tick();
      enc_oValid = 1'b0;
      @(negedge clk);
      check("rr_iValid", enc_iValid, 1);
      check("rr_iData", enc_iData, words[i % 4]);
      tick();
      enc_oValid = 1'b1;
      enc_oData  = code_q.pop_front();
    end
    req_valid = '0;
    tick();
    enc_oValid = 1'b0;

    // Single requester 2 with A5A5
    setData(2, 16'hA5A5);
    req_valid = 4'b0100;
    @(negedge clk);
    check("single_grant", req_ready, 4'b0100);
    expectWord(2, 16'hA5A5);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("single_iValid", enc_iValid, 1);
    check("single_iData", enc_iData, 16'hA5A5);
    check("single_ready_low", req_ready, 0);
    tick();
    returnOne(1'b0);

    // Encoder stall for 3 cycles
    setData(1, 16'h3C3C);
    req_valid  = 4'b0010;
    enc_oReady = 1'b0;
    @(negedge clk);
    check("stall_grant", req_ready, 4'b0010);
    expectWord(1, 16'h3C3C);
    tick();
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_iValid", enc_iValid, 1);
      check("stall_iData", enc_iData, 16'h3C3C);
      check("stall_ready_low", req_ready, 0);
      tick();
    end
    enc_oReady = 1'b1;
    @(negedge clk);
    check("stall_accept_iValid", enc_iValid, 1);
    tick();
    @(negedge clk);
    check("stall_done_iValid", enc_iValid, 0);
`ifdef HAMM_ARB_STATS_EN
    check("stat_stall", stat_stall, 3);
`endif
    tick();
    returnOne(1'b0);

    // Fill the tag FIFO with no returns: grants 2,3,0,1 then blocked
    loadWords();
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("fill_grant", req_ready, oneHot((2 + i) % 4));
      expectWord((2 + i) % 4, words[(2 + i) % 4]);
      tick();
      tick();
    end
    @(negedge clk);
    check("full_block", req_ready, 0);
    tick();
    @(negedge clk);
    check("full_block_again", req_ready, 0);
    tick();
    returnOne(1'b1);
    @(negedge clk);
    check("grant_after_pop", req_ready, 4'b0100);
    expectWord(2, words[2]);
    tick();
    req_valid = '0;
    tick();
    for (int i = 0; i < 4; i++) returnOne(i[0]);

    // Req 2 then req 0, results with toggling res_ready
    setData(2, 16'h1234);
    req_valid = 4'b0100;
    @(negedge clk);
    check("order_grant2", req_ready, 4'b0100);
    expectWord(2, 16'h1234);
    tick();
    req_valid = '0;
    tick();
    setData(0, 16'hBEEF);
    req_valid = 4'b0001;
    @(negedge clk);
    check("order_grant0", req_ready, 4'b0001);
    expectWord(0, 16'hBEEF);
    tick();
    req_valid = '0;
    tick();
    returnOne(1'b0);
    returnOne(1'b1);

    // Reset in the middle of an offer discards the word
    setData(3, 16'h7777);
    req_valid  = 4'b1000;
    enc_oReady = 1'b0;
    @(negedge clk);
    check("mid_grant3", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("mid_offer", enc_iValid, 1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_iValid", enc_iValid, 0);
    check("mid_rst_iData", enc_iData, 0);
    check("mid_rst_state", dbgState, 0);
    tick();
    rst = 1'b1;
    loadWords();
    req_valid  = 4'b1111;
    enc_oReady = 1'b1;
    @(negedge clk);
    check("post_rst_grant", req_ready, 4'b0001);
    expectWord(0, words[0]);
    tick();
    req_valid = '0;
    tick();
    returnOne(1'b0);

    // Orphan codeword with empty FIFO
    enc_oValid = 1'b1;
    enc_oData  = 21'h1F0F0;
    @(negedge clk);
    check("orphan_res_valid", res_valid, 0);
    check("orphan_iReady", enc_iReady, 0);
    tick();
    enc_oValid = 1'b0;
    @(negedge clk);
    check("orphan_set", err_orphan, 1);
    tick();
    @(negedge clk);
    check("orphan_sticky", err_orphan, 1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("orphan_cleared", err_orphan, 0);
    tick();
    rst = 1'b1;

    check("exp_q_drained", exp_q.size(), 0);
    check("code_q_drained", code_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
